// File: rtl/move_avg_n.sv
// Boxcar moving-average filter over the last 2^LOG_N signed samples, using a circular buffer and running sum.
// Optional build macro MOVE_AVG_ROUND_EN selects round-half-up with positive saturation instead of floor truncation.
module move_avg_n #(
  parameter int W     = 24,
  parameter int LOG_N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         primed
);

  localparam int               N       = 1 << LOG_N;
  localparam int               AW      = W + LOG_N;
  localparam logic [LOG_N:0]   N_CNT   = N[LOG_N:0];
  localparam logic [W-1:0]     MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [AW:0]      HALF    = {{AW{1'b0}}, 1'b1} << (LOG_N - 1);

  logic [W-1:0]   sbuf_q [N];
  logic [LOG_N-1:0] wp_q, wp_d;
  logic [LOG_N:0] cnt_q, cnt_d;
  logic [AW-1:0]  sum_q, sum_d;
  logic [AW-1:0]  sum_next_s;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           primed_q, primed_d;

  function automatic logic [AW-1:0] sext(input logic [W-1:0] v);
    return {{LOG_N{v[W-1]}}, v};
  endfunction

`ifdef MOVE_AVG_ROUND_EN
  // Extra headroom bit keeps the +half add from wrapping; only the positive side can exceed range.
  function automatic logic [W-1:0] avg(input logic [AW-1:0] s);
    logic [AW:0] rnd;
    logic [W:0]  q;
    rnd = {s[AW-1], s} + HALF;
    q   = rnd[AW:LOG_N];
    if (!q[W] && q[W-1]) begin
      return MAX_POS;
    end else begin
      return q[W-1:0];
    end
  endfunction
`else
  function automatic logic [W-1:0] avg(input logic [AW-1:0] s);
    return s[W+LOG_N-1:LOG_N];
  endfunction
`endif

  // Next-state for the running sum, pointer, fill count and output registers.
  always_comb begin
    sum_next_s  = sum_q + sext(in_data) - sext(sbuf_q[wp_q]);
    sum_d       = sum_q;
    wp_d        = wp_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    primed_d    = primed_q;
    if (clear) begin
      sum_d    = '0;
      wp_d     = '0;
      cnt_d    = '0;
      primed_d = 1'b0;
    end else if (in_valid) begin
      sum_d       = sum_next_s;
      wp_d        = wp_q + LOG_N'(1);
      cnt_d       = (cnt_q == N_CNT) ? N_CNT : cnt_q + (LOG_N+1)'(1);
      out_data_d  = avg(sum_next_s);
      out_valid_d = 1'b1;
      primed_d    = (cnt_d == N_CNT);
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      wp_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      wp_q        <= wp_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  // Sample window storage; zeroed on reset and clear so warm-up averages are zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sbuf_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) sbuf_q[i] <= '0;
    end else if (in_valid) begin
      sbuf_q[wp_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_move_avg_n.sv
// Self-checking bench for move_avg_n: directed plan steps plus random traffic against a queue-based window model.
module tb_move_avg_n;

  localparam int W     = 24;
  localparam int LOG_N = 2;
  localparam int N     = 1 << LOG_N;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         primed;

  int tests = 0;
  int fails = 0;

  longint       win[$];
  int           acc_cnt = 0;
  logic [W-1:0] exp_data = '0;
  logic         exp_valid = 1'b0;
  logic         exp_primed = 1'b0;

  move_avg_n #(.W(W), .LOG_N(LOG_N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .primed(primed)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] v(input int x);
    return x[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    win.delete();
    acc_cnt    = 0;
    exp_data   = '0;
    exp_valid  = 1'b0;
    exp_primed = 1'b0;
  endtask

  task automatic model_step(input logic vld, input logic clr, input logic [W-1:0] d);
    longint s;
    longint r;
    exp_valid = 1'b0;
    if (clr) begin
      win.delete();
      acc_cnt    = 0;
      exp_primed = 1'b0;
    end else if (vld) begin
      win.push_back(longint'($signed(d)));
      if (win.size() > N) void'(win.pop_front());
      s = 0;
      foreach (win[i]) s += win[i];
`ifdef MOVE_AVG_ROUND_EN
      r = (s + N/2) >>> LOG_N;
      if (r > MAXV) r = MAXV;
`else
      r = s >>> LOG_N;
`endif
      exp_data   = r[W-1:0];
      exp_valid  = 1'b1;
      acc_cnt++;
      exp_primed = (acc_cnt >= N);
    end
  endtask

  task automatic step(input logic vld, input logic clr, input logic [W-1:0] d);
    in_valid = vld;
    clear    = clr;
    in_data  = d;
    @(posedge clk);
    model_step(vld, clr, d);
    #1;
    chk("out_valid", W'(out_valid), W'(exp_valid));
    chk("out_data", out_data, exp_data);
    chk("primed", W'(primed), W'(exp_primed));
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, '0);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_primed", W'(primed), '0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d;
    logic         vv;
    logic         cc;

    do_reset();

    // Four back-to-back 1000s, then four -1000s across the pointer wrap.
    step(1'b1, 1'b0, v(1000)); chk("ramp1", out_data, v(250));
    step(1'b1, 1'b0, v(1000)); chk("ramp2", out_data, v(500));
    step(1'b1, 1'b0, v(1000)); chk("ramp3", out_data, v(750));
    chk("not_primed3", W'(primed), '0);
    step(1'b1, 1'b0, v(1000)); chk("ramp4", out_data, v(1000));
    chk("primed4", W'(primed), W'(1));
    step(1'b1, 1'b0, v(-1000)); chk("neg1", out_data, v(500));
    step(1'b1, 1'b0, v(-1000)); chk("neg2", out_data, v(0));
    step(1'b1, 1'b0, v(-1000)); chk("neg3", out_data, v(-500));
    step(1'b1, 1'b0, v(-1000)); chk("neg4", out_data, v(-1000));

    // Asynchronous reset mid-cycle while a sample is being offered.
    in_valid = 1'b1;
    in_data  = v(777);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out_data", out_data, '0);
    chk("async_out_valid", W'(out_valid), '0);
    chk("async_primed", W'(primed), '0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, v(400)); chk("post_rst_400", out_data, v(100));

    // Gap with idle cycles holds the output.
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, v(1000)); chk("gap_first", out_data, v(250));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      chk("gap_hold", out_data, v(250));
      chk("gap_valid", W'(out_valid), '0);
    end
    step(1'b1, 1'b0, v(1000)); chk("gap_second", out_data, v(500));

    // Clear wins over a simultaneous sample.
    step(1'b1, 1'b0, v(1000));
    step(1'b1, 1'b0, v(1000));
    chk("primed_before_clear", W'(primed), W'(1));
    step(1'b1, 1'b1, v(1000));
    chk("clear_no_valid", W'(out_valid), '0);
    chk("clear_primed", W'(primed), '0);
    step(1'b1, 1'b0, v(400)); chk("after_clear_400", out_data, v(100));
    chk("after_clear_primed", W'(primed), '0);

    // Full-scale extremes.
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 24'h7FFFFF);
    chk("max_final", out_data, 24'h7FFFFF);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 24'h800000);
    chk("min_final", out_data, 24'h800000);

    // Single small sample shows truncation versus rounding.
    do_reset();
    step(1'b1, 1'b0, v(3));
`ifdef MOVE_AVG_ROUND_EN
    chk("single3", out_data, v(1));
`else
    chk("single3", out_data, v(0));
`endif

    // Random traffic including extremes and occasional clears.
    for (int i = 0; i < 400; i++) begin
      vv = ($urandom_range(0, 3) != 0);
      cc = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0:       d = 24'h7FFFFF;
        1:       d = 24'h800000;
        default: d = $urandom();
      endcase
      step(vv, cc, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
